des_dispatch: RTL and testbench
===============================

Name: des_dispatch

Overview:
- Work dispatcher between the register block's job controls and the array of N DES key-search cores, in the fast core clock domain.
- Accepts one job: base key, chunk count and hit flag handling. Splits the job into fixed-size key chunks and hands each chunk to an idle core with a run pulse and a per-core start key.
- Tracks each core's run/busy lifecycle, captures the first hit, stops issuing, drains in-flight cores, then reports done.

Parameters:
- N, 16, number of cores served.
- CHUNK_LOG, 24, log2 of keys per chunk; chunk stride is 2^CHUNK_LOG.
- CNT_W, 32, width of the chunk count.

Ports:
- clk  in  1  fast core clock.
- rst  in  1  synchronous reset, active-high.
- job_valid  in  1  job request.
- job_ready  out  1  high only in IDLE.
- job_base  in  64  first key of the job.
- job_chunks  in  CNT_W  number of chunks to issue.
- abort  in  1  stop issuing; drain in-flight cores.
- core_run  out  N  one-cycle launch pulse per core.
- core_start  out  64*N  per-core start key; held stable from launch until the next launch of that core.
- core_busy  in  N  core working.
- core_hit  in  N  sampled on the busy falling edge; 1 = key found.
- core_result  in  64*N  key reported by the core; valid when core_hit is sampled.
- done  out  1  level; high in DONE until the next job is accepted.
- found  out  1  a hit was captured in this job.
- found_key  out  64  captured key.
- chunks_left  out  CNT_W  chunks not yet issued.

Behaviour:
- Reset values: all outputs 0, job_ready = 1, FSM = IDLE, all slots FREE, round-robin pointer 0.
- Per-core slot FSM:
  - FREE -> LAUNCHED when issued.
  - LAUNCHED -> RUNNING when core_busy[i] = 1.
  - RUNNING -> FREE when core_busy[i] = 0. This cycle is the completion event; core_hit[i] and core_result[i] are sampled in it.
  - There is no timeout. A LAUNCHED core stays LAUNCHED until busy rises.
- Main FSM:
  - IDLE: on job_valid & job_ready, latch next_key = job_base and chunks_left = job_chunks; clear found, found_key and done.
    - If job_chunks = 0, go to DONE next cycle.
    - Otherwise go to ISSUE.
  - ISSUE: at most one launch per cycle. Round-robin pick among FREE slots, starting at pointer+1 after the previous grant.
    - On a launch: core_start[i] <= next_key; core_run[i] = 1 for exactly one cycle (registered); next_key += 2^CHUNK_LOG, mod 2^64, wrap allowed; chunks_left -= 1.
    - If chunks_left reaches 0, or a hit is captured, or abort = 1, go to DRAIN.
  - DRAIN: no launches. Go to DONE when all slots are FREE.
  - DONE: done = 1, job_ready = 0 for one cycle, then IDLE. done stays high until the next job is accepted.
- Hit capture:
  - First completion with core_hit = 1 sets found and found_key.
  - If several hits complete in the same cycle, the lowest index wins.
  - Later hits are ignored.
  - Hits completing during DRAIN are still captured if found = 0.
- A hit, abort, or last-chunk launch in the same cycle as a launch: the launch still completes, then the FSM moves to DRAIN.
- abort in IDLE or DONE is ignored.
- job_valid outside IDLE is ignored; there is no queueing.
- rst mid-job returns to the reset state immediately. Core busy state is not tracked across reset; after reset every slot is FREE.
- Latency: first core_run 2 cycles after job acceptance.

Optional Feature:
- DES_DISPATCH_STATS_EN defined:
  - adds outputs job_cycles (48 bits): cycles from acceptance to DONE, saturating.
  - adds output chunks_done (CNT_W): completions counted.
  - both clear on acceptance and hold after DONE.
- Undefined: the ports and counters are absent. Functional behaviour is identical.

Decomposition:
- Package des_pkg:
  - KEY_W = 64.
  - main FSM enum {IDLE, ISSUE, DRAIN, DONE}.
  - slot enum {FREE, LAUNCHED, RUNNING}.
  - the chunk-stride function.
- Sub-module des_rr_arb: N-wide round-robin arbiter.
  - Inputs: request vector (FREE & issuing), advance.
  - Outputs: one-hot grant and index.

Test Plan:
- Basic issue: N = 4 model cores with busy 10 cycles, base 0x100, chunks 6, CHUNK_LOG 4 -> start keys 0x100, 0x110, 0x120, 0x130, then 0x140, 0x150 on the first freed cores, no hit -> done = 1, found = 0, chunks_left = 0.
- Hit and drain: hit on chunk 2 with result 0x12345 while chunks remain -> no further core_run; done only after all busy = 0; found_key = 0x12345.
- Simultaneous hits: cores 1 and 3 complete with hit in the same cycle, results A and B -> found_key = A.
- Zero / wrap: job_chunks = 0 -> done 2 cycles after acceptance with no core_run. Base 0xFFFF_FFFF_FFFF_FFF0, CHUNK_LOG 4, chunks 2 -> second start = 0x0.
- Abort and reset: abort mid-ISSUE -> no new launches, drain, done with found = 0. rst while cores are busy -> all outputs at reset values the next cycle, job_ready = 1.
- Slow launch: a core delays busy by 5 cycles -> the slot is not reissued until busy rises then falls. The arbiter skips it and uses other FREE cores.

Source files
------------

// File: rtl/des_pkg.sv
// Shared types and helpers for the DES key-search work dispatcher.
// Holds the key width, the main/slot state encodings and the chunk stride.
package des_pkg;

    localparam int KEY_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } main_state_e;

    typedef enum logic [1:0] {
        FREE,
        LAUNCHED,
        RUNNING
    } slot_state_e;

    // Distance in key space between consecutive chunk start keys.
    function automatic logic [KEY_W-1:0] chunk_stride(input int unsigned log2_keys);
        return 64'd1 << log2_keys;
    endfunction

endpackage

// File: rtl/des_rr_arb.sv
// N-wide round-robin arbiter for the dispatcher.
// The search starts at the index after the last grant; the pointer moves
// only when a grant is actually taken (i_advance with a request present).
module des_rr_arb #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N-1:0]     i_req,
    input  logic             i_advance,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic             w_any;
    int               w_j;

    // Rotating priority search beginning at r_ptr.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        w_any = 1'b0;
        w_j   = 0;
        for (int k = 0; k < N; k++) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            if (!w_any && i_req[w_j]) begin
                w_any        = 1'b1;
                o_gnt[w_j]   = 1'b1;
                o_idx        = IDX_W'(w_j);
            end
        end
    end

    // Move the priority pointer just past the index that was granted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_advance && w_any) begin
            if (int'(o_idx) == N - 1) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= o_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/des_dispatch.sv
// Work dispatcher between the job controls and an array of DES key-search
// cores. Splits a job into 2^CHUNK_LOG-key chunks, launches them round-robin
// on free cores, captures the first hit, drains and reports done.
// Optional statistics outputs (job_cycles, chunks_done) are built only when
// DES_DISPATCH_STATS_EN is defined.
module des_dispatch
    import des_pkg::*;
#(
    parameter int N         = 16,
    parameter int CHUNK_LOG = 24,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [KEY_W-1:0]     job_base,
    input  logic [CNT_W-1:0]     job_chunks,
    input  logic                 abort,
    output logic [N-1:0]         core_run,
    output logic [KEY_W*N-1:0]   core_start,
    input  logic [N-1:0]         core_busy,
    input  logic [N-1:0]         core_hit,
    input  logic [KEY_W*N-1:0]   core_result,
    output logic                 done,
    output logic                 found,
    output logic [KEY_W-1:0]     found_key,
    output logic [CNT_W-1:0]     chunks_left
`ifdef DES_DISPATCH_STATS_EN
    ,
    output logic [47:0]          job_cycles,
    output logic [CNT_W-1:0]     chunks_done
`endif
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    main_state_e        r_state;
    slot_state_e        r_slot [N];
    logic [KEY_W-1:0]   r_next_key;
    logic [CNT_W-1:0]   r_chunks_left;
    logic               r_job_ready;
    logic               r_done;
    logic               r_found;
    logic [KEY_W-1:0]   r_found_key;
    logic [N-1:0]       r_core_run;
    logic [KEY_W*N-1:0] r_core_start;

    logic [N-1:0]       w_free;
    logic [N-1:0]       w_cmpl;
    logic [N-1:0]       w_req;
    logic [N-1:0]       w_gnt;
    logic [IDX_W-1:0]   w_idx;
    logic               w_launch;
    logic               w_all_free;
    logic               w_hit_any;
    logic [KEY_W-1:0]   w_hit_key;
    logic               w_hit_capture;

    // Per-slot decode: free slots and completion events (busy falling).
    always_comb begin
        w_free = '0;
        w_cmpl = '0;
        for (int i = 0; i < N; i++) begin
            w_free[i] = (r_slot[i] == FREE);
            w_cmpl[i] = (r_slot[i] == RUNNING) && !core_busy[i];
        end
    end

    assign w_req      = w_free & {N{r_state == ISSUE}};
    assign w_launch   = |w_gnt;
    assign w_all_free = &w_free;

    // Lowest-index hit among this cycle's completions wins.
    always_comb begin
        w_hit_any = 1'b0;
        w_hit_key = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_cmpl[i] && core_hit[i]) begin
                w_hit_any = 1'b1;
                w_hit_key = core_result[i*KEY_W +: KEY_W];
            end
        end
    end

    assign w_hit_capture = w_hit_any && !r_found &&
                           ((r_state == ISSUE) || (r_state == DRAIN));

    des_rr_arb #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (w_req),
        .i_advance (r_state == ISSUE),
        .o_gnt     (w_gnt),
        .o_idx     (w_idx)
    );

    // Slot lifecycle: FREE -> LAUNCHED on grant, -> RUNNING on busy, -> FREE on busy low.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_slot[i] <= FREE;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                case (r_slot[i])
                    FREE:     if (w_gnt[i])      r_slot[i] <= LAUNCHED;
                    LAUNCHED: if (core_busy[i])  r_slot[i] <= RUNNING;
                    RUNNING:  if (!core_busy[i]) r_slot[i] <= FREE;
                    default:                     r_slot[i] <= FREE;
                endcase
            end
        end
    end

    // Main job FSM with registered launch outputs and hit capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_job_ready   <= 1'b1;
            r_done        <= 1'b0;
            r_found       <= 1'b0;
            r_found_key   <= '0;
            r_chunks_left <= '0;
            r_core_run    <= '0;
            r_core_start  <= '0;
        end else begin
            r_core_run <= '0;
            if (w_hit_capture) begin
                r_found     <= 1'b1;
                r_found_key <= w_hit_key;
            end
            case (r_state)
                IDLE: begin
                    if (job_valid && r_job_ready) begin
                        r_next_key    <= job_base;
                        r_chunks_left <= job_chunks;
                        r_found       <= 1'b0;
                        r_found_key   <= '0;
                        r_done        <= 1'b0;
                        r_job_ready   <= 1'b0;
                        r_state       <= (job_chunks == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_launch) begin
                        r_core_run                               <= w_gnt;
                        r_core_start[int'(w_idx)*KEY_W +: KEY_W] <= r_next_key;
                        r_next_key    <= r_next_key + chunk_stride(CHUNK_LOG);
                        r_chunks_left <= r_chunks_left - 1'b1;
                    end
                    if ((w_launch && (r_chunks_left == CNT_W'(1))) || w_hit_capture || abort) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_all_free) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done      <= 1'b1;
                    r_job_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign job_ready   = r_job_ready;
    assign done        = r_done;
    assign found       = r_found;
    assign found_key   = r_found_key;
    assign chunks_left = r_chunks_left;
    assign core_run    = r_core_run;
    assign core_start  = r_core_start;

`ifdef DES_DISPATCH_STATS_EN
    logic [47:0]      r_job_cycles;
    logic [CNT_W-1:0] r_chunks_done;
    logic [CNT_W-1:0] w_cmpl_cnt;

    // Number of cores completing in this cycle.
    always_comb begin
        w_cmpl_cnt = '0;
        for (int i = 0; i < N; i++) begin
            if (w_cmpl[i]) begin
                w_cmpl_cnt = w_cmpl_cnt + 1'b1;
            end
        end
    end

    // Job statistics: cleared on acceptance, frozen once back in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_job_cycles  <= '0;
            r_chunks_done <= '0;
        end else if ((r_state == IDLE) && job_valid && r_job_ready) begin
            r_job_cycles  <= '0;
            r_chunks_done <= '0;
        end else if (r_state != IDLE) begin
            if (r_job_cycles != '1) begin
                r_job_cycles <= r_job_cycles + 1'b1;
            end
            r_chunks_done <= r_chunks_done + w_cmpl_cnt;
        end
    end

    assign job_cycles  = r_job_cycles;
    assign chunks_done = r_chunks_done;
`endif

endmodule

// File: tb/tb_des_dispatch.sv
// Self-checking bench for des_dispatch with four behavioural key-search cores.
module tb_des_dispatch;

    localparam int NC = 4;

    typedef struct {
        logic [63:0] key;
        int          core;
        bit          chk;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            job_valid;
    logic            job_ready;
    logic [63:0]     job_base;
    logic [31:0]     job_chunks;
    logic            abort;
    logic [NC-1:0]   core_run;
    logic [64*NC-1:0] core_start;
    logic [NC-1:0]   core_busy;
    logic [NC-1:0]   core_hit;
    logic [64*NC-1:0] core_result;
    logic            done;
    logic            found;
    logic [63:0]     found_key;
    logic [31:0]     chunks_left;
`ifdef DES_DISPATCH_STATS_EN
    logic [47:0]     job_cycles;
    logic [31:0]     chunks_done;
`endif

    int checks = 0;
    int errors = 0;
    int run_cnt = 0;
    exp_t exp_q[$];

    // Core model controls
    int          dly [NC];
    int          dur [NC];
    int          phase [NC];
    int          cnt [NC];
    logic [63:0] skey [NC];
    logic [63:0] hk0, hk1, res0, res1;
    logic        found_prev = 1'b0;

    always #5 clk = ~clk;

    des_dispatch #(
        .N         (NC),
        .CHUNK_LOG (4),
        .CNT_W     (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_base    (job_base),
        .job_chunks  (job_chunks),
        .abort       (abort),
        .core_run    (core_run),
        .core_start  (core_start),
        .core_busy   (core_busy),
        .core_hit    (core_hit),
        .core_result (core_result),
        .done        (done),
        .found       (found),
        .found_key   (found_key),
        .chunks_left (chunks_left)
`ifdef DES_DISPATCH_STATS_EN
        ,
        .job_cycles  (job_cycles),
        .chunks_done (chunks_done)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [63:0] key, input int core, input bit chk);
        exp_t e;
        e.key  = key;
        e.core = core;
        e.chk  = chk;
        exp_q.push_back(e);
    endtask

    task automatic start_job(input logic [63:0] base, input logic [31:0] chunks);
        @(negedge clk);
        job_valid  = 1'b1;
        job_base   = base;
        job_chunks = chunks;
        @(negedge clk);
        job_valid  = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(tag, done, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Behavioural cores: run -> (dly) busy -> (dur) busy low with hit/result.
    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (rst) begin
                phase[i]     <= 0;
                cnt[i]       <= 0;
                core_busy[i] <= 1'b0;
                core_hit[i]  <= 1'b0;
            end else begin
                case (phase[i])
                    0: if (core_run[i]) begin
                        skey[i]  <= core_start[i*64 +: 64];
                        cnt[i]   <= dly[i];
                        phase[i] <= 1;
                    end
                    1: if (cnt[i] <= 1) begin
                        core_busy[i] <= 1'b1;
                        cnt[i]       <= dur[i];
                        phase[i]     <= 2;
                    end else begin
                        cnt[i] <= cnt[i] - 1;
                    end
                    2: if (cnt[i] <= 1) begin
                        core_busy[i] <= 1'b0;
                        phase[i]     <= 0;
                        core_hit[i]  <= (skey[i] == hk0) || (skey[i] == hk1);
                        core_result[i*64 +: 64] <= (skey[i] == hk0) ? res0 :
                                                   ((skey[i] == hk1) ? res1 : skey[i]);
                    end else begin
                        cnt[i] <= cnt[i] - 1;
                    end
                    default: phase[i] <= 0;
                endcase
            end
        end
    end

    // Scoreboard: every launch pops the next expected start key (and core).
    always @(negedge clk) begin
        if (!rst) begin
            if (core_run != '0) begin
                check("run_after_hit", found_prev, 0);
            end
            for (int i = 0; i < NC; i++) begin
                if (core_run[i]) begin
                    exp_t e;
                    run_cnt++;
                    check("run_core_idle", phase[i], 0);
                    if (exp_q.size() == 0) begin
                        check("run_extra", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("start_key", core_start[i*64 +: 64], e.key);
                        if (e.chk) begin
                            check("start_core", i, e.core);
                        end
                    end
                end
            end
        end
        found_prev = found;
    end

    initial begin
        int slow_cores[8];
        slow_cores = '{0, 1, 2, 3, 0, 1, 3, 2};
        rst        = 1'b1;
        job_valid  = 1'b0;
        job_base   = '0;
        job_chunks = '0;
        abort      = 1'b0;
        core_result = '0;
        hk0  = 64'hDEAD_BEEF_0000_0001;
        hk1  = 64'hDEAD_BEEF_0000_0002;
        res0 = '0;
        res1 = '0;
        for (int i = 0; i < NC; i++) begin
            dly[i] = 1;
            dur[i] = 10;
        end
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ready", job_ready, 1);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_fkey", found_key, 0);
        check("rst_left", chunks_left, 0);
        check("rst_run", core_run, 0);
        check("rst_start_lo", core_start[127:0], 0);
        check("rst_start_hi", core_start[255:128], 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic issue: 6 chunks over 4 cores
        for (int k = 0; k < 6; k++) push_exp(64'h100 + 64'(16 * k), k % 4, 1'b1);
        start_job(64'h100, 6);
        check("acc_ready", job_ready, 0);
        check("acc_left", chunks_left, 6);
        check("acc_run", core_run, 0);
        @(negedge clk);
        check("lat_run", core_run, 1);
        job_valid  = 1'b1;
        job_base   = 64'h9000;
        job_chunks = 1;
        @(negedge clk);
        job_valid  = 1'b0;
        wait_done(300, "basic_done");
        check("basic_found", found, 0);
        check("basic_left", chunks_left, 0);
        check("basic_ready", job_ready, 1);
        check("basic_q_empty", exp_q.size(), 0);
`ifdef DES_DISPATCH_STATS_EN
        check("basic_chunks_done", chunks_done, 6);
`endif
        @(negedge clk);
        check("basic_done_hold", done, 1);

        // Hit on chunk 2, then drain
        do_reset();
        hk0  = 64'h120;
        res0 = 64'h12345;
        for (int k = 0; k < 20; k++) push_exp(64'h100 + 64'(16 * k), 0, 1'b0);
        start_job(64'h100, 20);
        wait_done(300, "hit_done");
        check("hit_found", found, 1);
        check("hit_key", found_key, 64'h12345);
        check("hit_left", chunks_left, 14);
        check("hit_busy_idle", core_busy, 0);
        check("hit_q_left", exp_q.size(), 14);
        hk0 = 64'hDEAD_BEEF_0000_0001;

        // Simultaneous hits on cores 1 and 3
        do_reset();
        dur[1] = 12;
        hk0  = 64'h210;
        res0 = 64'hAAAA_0001;
        hk1  = 64'h230;
        res1 = 64'hBBBB_0003;
        for (int k = 0; k < 4; k++) push_exp(64'h200 + 64'(16 * k), k, 1'b1);
        start_job(64'h200, 4);
        wait_done(300, "sim_done");
        check("sim_found", found, 1);
        check("sim_key", found_key, 64'hAAAA_0001);
        check("sim_q_empty", exp_q.size(), 0);
        dur[1] = 10;
        hk0 = 64'hDEAD_BEEF_0000_0001;
        hk1 = 64'hDEAD_BEEF_0000_0002;

        // Zero chunks
        start_job(64'h5000, 0);
        check("zero_done_early", done, 0);
        check("zero_ready", job_ready, 0);
        check("zero_found_clr", found, 0);
        @(negedge clk);
        check("zero_done", done, 1);
        check("zero_ready_back", job_ready, 1);
        check("zero_run", core_run, 0);

        // Key wrap
        push_exp(64'hFFFF_FFFF_FFFF_FFF0, 0, 1'b0);
        push_exp(64'h0, 0, 1'b0);
        start_job(64'hFFFF_FFFF_FFFF_FFF0, 2);
        wait_done(300, "wrap_done");
        check("wrap_q_empty", exp_q.size(), 0);

        // Abort mid-issue
        do_reset();
        for (int k = 0; k < 20; k++) push_exp(64'h1000 + 64'(16 * k), k, 1'b1);
        run_cnt = 0;
        start_job(64'h1000, 20);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(300, "abort_done");
        check("abort_found", found, 0);
        check("abort_left", chunks_left, 17);
        check("abort_runs", run_cnt, 3);

        // Reset while cores are busy
        exp_q.delete();
        for (int k = 0; k < 20; k++) push_exp(64'h2000 + 64'(16 * k), 0, 1'b0);
        start_job(64'h2000, 20);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_ready", job_ready, 1);
        check("mrst_done", done, 0);
        check("mrst_left", chunks_left, 0);
        check("mrst_run", core_run, 0);
        check("mrst_start_lo", core_start[127:0], 0);
        check("mrst_start_hi", core_start[255:128], 0);
        @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);

        // Slow busy on core 2: arbiter skips it until it completes
        dly[2] = 5;
        for (int k = 0; k < 8; k++) push_exp(64'h3000 + 64'(16 * k), slow_cores[k], 1'b1);
        start_job(64'h3000, 8);
        wait_done(300, "slow_done");
        check("slow_q_empty", exp_q.size(), 0);
        check("slow_left", chunks_left, 0);
        dly[2] = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
